sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Memory-side neighbour of the pipeline's memory stage. Accepts one 32-bit word read or write per request from that stage.
- Performs each request as two sequential 16-bit accesses on the external SRAM (EP2C35 board SRAM: 18-bit address, 16-bit data, active-low write enable).
- Holds the pipeline with SRAM_NOT_READY until the word completes.
- Replaces the combinational data-memory path. All SRAM pin timing lives in this block.

Parameters:
- DATA_BASE, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles each 16-bit half-access is held on the pins (range 1..7).

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting low resets immediately; release is synchronised by the top level.
- read  input  1  word read request from memory stage; level, held while stalled.
- write  input  1  word write request; level, held while stalled.
- address  input  32  byte address (ALU result).
- writedata  input  32  store data.
- readdata  output  32  loaded word; registered.
- SRAM_NOT_READY  output  1  stall to pipeline; high while a request is pending and not complete.
- SRAMaddress  output  18  SRAM half-word address.
- SRAMWEn  output  1  SRAM write enable, active low.
- SRAMdata  inout  16  SRAM data bus; driven only during write phases, otherwise high-Z.

Behaviour:
- Address map:
  - word = (address - DATA_BASE) >> 2, truncated to 17 bits. Addresses below DATA_BASE wrap modulo 2^17 words.
  - address[1:0] is ignored.
  - Low half is at SRAMaddress = {word, 1'b0}; high half is at {word, 1'b1}.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if write | read is high, latch address, writedata and op (write has priority if both are high), clear the counter, and go to LO.
  - LO: hold for WAIT_CYCLES cycles, then go to HI and clear the counter.
  - HI: hold for WAIT_CYCLES cycles, then go to DONE.
  - DONE: lasts one cycle, then returns to IDLE unconditionally.
- SRAM_NOT_READY = (read | write) & (state != DONE). It is combinational from state and inputs, so it is high in the same cycle a request first appears.
- Latency for the default WAIT_CYCLES=2:
  - Request cycle 0 (IDLE), LO in cycles 1-2, HI in cycles 3-4, DONE in cycle 5.
  - SRAM_NOT_READY is high in cycles 0-4 and low in cycle 5.
  - In general the stall lasts 1 + 2*WAIT_CYCLES cycles.
- Write phases:
  - SRAMWEn = 0 in LO and HI.
  - SRAMdata = writedata_latched[15:0] in LO, [31:16] in HI.
  - Address is stable for the whole phase. SRAMWEn rises in DONE.
- Read phases:
  - SRAMWEn = 1 and SRAMdata is high-Z.
  - SRAMdata is sampled into lo_q on the last cycle of LO and into hi_q on the last cycle of HI.
  - readdata = {hi_q, lo_q} is updated at entry to DONE and holds its value until the next read completes. Writes do not alter readdata.
- Idle outputs: SRAMWEn = 1, SRAMdata = Z, SRAMaddress = the last latched value.
- Once latched, a request always completes, even if read/write deassert mid-operation. The inputs are not re-sampled until IDLE.
- Back-to-back requests: in the cycle after DONE the FSM is in IDLE. A new request raises SRAM_NOT_READY again immediately. There is no combinational loop because the pipeline registers advance on the DONE edge.
- Reset values (rst low, any state, including mid-write): state = IDLE, counter = 0, readdata = 0, lo_q = hi_q = 0, SRAMaddress = 0, SRAMWEn = 1, SRAMdata released to Z. SRAM_NOT_READY follows read | write.

Decomposition:
- Shared package sram_pkg:
  - state encoding (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3)
  - SRAM_ADDR_W = 18 and SRAM_DATA_W = 16
  - default DATA_BASE
- One natural sub-module: sram_phase_counter. It is a small loadable counter with a clear input and a terminal-count output at WAIT_CYCLES-1. It is reused by LO and HI.
- The tri-state driver stays in the top of this block.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - write address=1028, data=0xDEADBEEF → SRAMaddress=2 with data 0xBEEF, then 3 with data 0xDEAD, WEn low for 4 cycles, stall for 5 cycles.
  - Following read of 1028 → readdata=0xDEADBEEF in the DONE cycle.
- Stall timing: read asserted at cycle 0 → SRAM_NOT_READY=1 in cycles 0-4 and 0 in cycle 5. Sweep WAIT_CYCLES=1 → stall lasts 3 cycles.
- Read and write both high, address=1024, data=0x12345678 → write performed (WEn low); a subsequent read returns 0x12345678 and readdata is unchanged by the write.
- Wrap and alignment:
  - address=1027 → same word as 1024 (SRAMaddress 0/1).
  - address=0 → word 0x1FF00, SRAMaddress 0x3FE00/0x3FE01.
- rst asserted low during the HI phase of a write → WEn goes to 1 and SRAMdata to Z immediately, state IDLE. After release, a held request restarts from LO and completes correctly.
- Request dropped mid-LO → operation still finishes through DONE. SRAM_NOT_READY follows the request and goes low when the request is dropped.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the word-wide SRAM controller: pin widths,
// FSM state encoding, default address map and the byte-to-word mapping.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WORD_W      = SRAM_ADDR_W - 1;  // one 32-bit word = two SRAM half-words
    localparam int COUNT_W     = 3;                // enough for WAIT_CYCLES up to 7

    localparam logic [31:0] DEFAULT_DATA_BASE = 32'd1024;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Word index of a byte address relative to the data base. The low two
    // address bits are dropped; addresses below the base wrap modulo 2^17.
    function automatic logic [WORD_W-1:0] word_index(input logic [31:0] addr,
                                                     input logic [31:0] base);
        return WORD_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter that times one half-word access on the SRAM pins.
// Cleared at the start of each phase; tc_o marks the last cycle of a phase.
module sram_phase_counter
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [COUNT_W-1:0] TC_VALUE = COUNT_W'(WAIT_CYCLES - 1);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    assign tc_o = (count_q == TC_VALUE);

    // Next count: clear wins, otherwise advance until terminal count and hold.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Word-wide data-memory port for the pipeline's memory stage. Each 32-bit
// read or write is carried out as two 16-bit accesses (low half, then high
// half) on the board SRAM, and the pipeline is stalled until the word is done.
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read,
    input  logic                   write,
    input  logic [31:0]            address,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    output logic                   SRAM_NOT_READY,
    output logic [SRAM_ADDR_W-1:0] SRAMaddress,
    output logic                   SRAMWEn,
    inout  wire  [SRAM_DATA_W-1:0] SRAMdata
);

    logic [1:0]             state_q, state_d;
    logic                   op_write_q, op_write_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] lo_q, lo_d;
    logic [31:0]            rdata_q, rdata_d;

    logic phase_tc;
    logic in_phase;
    logic cnt_clear;
    logic drive_en;
    logic [SRAM_DATA_W-1:0] drive_val;

    assign in_phase  = (state_q == ST_LO) || (state_q == ST_HI);
    assign cnt_clear = (state_q == ST_IDLE) || ((state_q == ST_LO) && phase_tc);

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .en_i    (in_phase),
        .tc_o    (phase_tc)
    );

    // Pin-side outputs: write enable and data driver are active only while a
    // write phase is on the pins, so reset releases the bus immediately.
    assign drive_en       = op_write_q && in_phase;
    assign drive_val      = (state_q == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAMdata       = drive_en ? drive_val : 'z;
    assign SRAMWEn        = ~drive_en;
    assign SRAMaddress    = addr_q;
    assign readdata       = rdata_q;
    assign SRAM_NOT_READY = (read || write) && (state_q != ST_DONE);

    // FSM next state: latch the request in IDLE, then sequence low and high halves.
    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (write || read) begin
                    op_write_d = write;
                    wdata_d    = writedata;
                    addr_d     = {word_index(address, DATA_BASE), 1'b0};
                    state_d    = ST_LO;
                end
            end
            ST_LO: begin
                if (phase_tc) begin
                    if (!op_write_q) lo_d = SRAMdata;
                    addr_d[0] = 1'b1;
                    state_d   = ST_HI;
                end
            end
            ST_HI: begin
                if (phase_tc) begin
                    if (!op_write_q) rdata_d = {SRAMdata, lo_q};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_write_q <= 1'b0;
            wdata_q    <= '0;
            addr_q     <= '0;
            lo_q       <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM on the bus.
// Inputs change 1 ns after a rising edge; outputs are checked 2 ns later.
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        read, write;
    logic [31:0] address, writedata;
    wire  [31:0] readdata;
    wire         nr;
    wire  [17:0] sram_addr;
    wire         wen;
    wire  [15:0] sram_data;

    // Second instance with single-cycle phases; its bus has no SRAM attached.
    logic        read1;
    logic        write1;
    logic [31:0] address1, writedata1;
    wire  [31:0] readdata1;
    wire         nr1;
    wire  [17:0] sram_addr1;
    wire         wen1;
    wire  [15:0] sram_data1;

    // Behavioural SRAM plus a bench-side bus driver used to probe bus release.
    logic [15:0] mem [0:262143];
    logic        tb_drv_en;
    logic [15:0] tb_drv_val;

    assign sram_data = tb_drv_en ? tb_drv_val : 'z;
    assign sram_data = (wen && !tb_drv_en) ? mem[sram_addr] : 'z;

    // SRAM write port.
    always @(posedge clk) begin
        if (!wen) mem[sram_addr] <= sram_data;
    end

    sram_controller #(
        .DATA_BASE   (32'd1024),
        .WAIT_CYCLES (2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .read           (read),
        .write          (write),
        .address        (address),
        .writedata      (writedata),
        .readdata       (readdata),
        .SRAM_NOT_READY (nr),
        .SRAMaddress    (sram_addr),
        .SRAMWEn        (wen),
        .SRAMdata       (sram_data)
    );

    sram_controller #(
        .DATA_BASE   (32'd1024),
        .WAIT_CYCLES (1)
    ) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .read           (read1),
        .write          (write1),
        .address        (address1),
        .writedata      (writedata1),
        .readdata       (readdata1),
        .SRAM_NOT_READY (nr1),
        .SRAMaddress    (sram_addr1),
        .SRAMWEn        (wen1),
        .SRAMdata       (sram_data1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word write with WAIT_CYCLES=2; exp_a0 is the hand-computed low-half SRAM address.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [17:0] exp_a0, input logic also_read);
        tick();
        write = 1'b1; read = also_read; address = addr; writedata = data;
        #2;
        check({tag, " stall c0"}, nr, 1);
        check({tag, " wen c0"}, wen, 1);
        for (int c = 1; c <= 4; c++) begin
            tick(); #2;
            check($sformatf("%s stall c%0d", tag, c), nr, 1);
            check($sformatf("%s wen c%0d", tag, c), wen, 0);
            check($sformatf("%s addr c%0d", tag, c), sram_addr, (c <= 2) ? exp_a0 : (exp_a0 | 18'd1));
            check($sformatf("%s data c%0d", tag, c), sram_data, (c <= 2) ? data[15:0] : data[31:16]);
        end
        tick(); #2;
        check({tag, " stall done"}, nr, 0);
        check({tag, " wen done"}, wen, 1);
        tick();
        write = 1'b0; read = 1'b0;
        #2;
        check({tag, " stall idle"}, nr, 0);
        check({tag, " addr idle"}, sram_addr, exp_a0 | 18'd1);
    endtask

    // One word read with WAIT_CYCLES=2.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [17:0] exp_a0, input logic [31:0] exp_data);
        tick();
        read = 1'b1; address = addr;
        #2;
        check({tag, " stall c0"}, nr, 1);
        for (int c = 1; c <= 4; c++) begin
            tick(); #2;
            check($sformatf("%s stall c%0d", tag, c), nr, 1);
            check($sformatf("%s wen c%0d", tag, c), wen, 1);
            check($sformatf("%s addr c%0d", tag, c), sram_addr, (c <= 2) ? exp_a0 : (exp_a0 | 18'd1));
        end
        tick(); #2;
        check({tag, " stall done"}, nr, 0);
        check({tag, " rdata done"}, readdata, exp_data);
        tick();
        read = 1'b0;
        #2;
        check({tag, " rdata hold"}, readdata, exp_data);
    endtask

    initial begin
        rst = 1'b0; read = 1'b1; write = 1'b0; address = 32'd0; writedata = 32'd0;
        read1 = 1'b0; write1 = 1'b0; address1 = 32'd1028; writedata1 = 32'd0;
        tb_drv_en = 1'b0; tb_drv_val = 16'h0000;

        // Reset state; stall follows the request even in reset.
        tick(); tick(); #2;
        check("rst stall follows read", nr, 1);
        check("rst wen", wen, 1);
        check("rst addr", sram_addr, 0);
        check("rst rdata", readdata, 0);
        check("rst state", u_dut.state_q, 0);
        check("rst dut1 stall", nr1, 0);
        read = 1'b0; #1;
        check("rst stall no req", nr, 0);
        tick();
        rst = 1'b1;

        // Write then read back.
        do_write("wr1028", 32'd1028, 32'hDEADBEEF, 18'd2, 1'b0);
        check("rdata after write", readdata, 0);
        do_read("rd1028", 32'd1028, 18'd2, 32'hDEADBEEF);

        // Read and write together: write wins and readdata is untouched.
        do_write("both1024", 32'd1024, 32'h12345678, 18'd0, 1'b1);
        check("rdata after both", readdata, 32'hDEADBEEF);
        do_read("rd1024", 32'd1024, 18'd0, 32'h12345678);

        // Alignment: 1027 maps to the same word as 1024.
        do_write("wr1027", 32'd1027, 32'hCAFEF00D, 18'd0, 1'b0);
        do_read("rd1024b", 32'd1024, 18'd0, 32'hCAFEF00D);

        // Wrap: address 0 lands in word 0x1FF00.
        do_write("wr0", 32'd0, 32'h0BADC0DE, 18'h3FE00, 1'b0);
        do_read("rd0", 32'd0, 18'h3FE00, 32'h0BADC0DE);

        // Reset during the HI phase of a write, then restart of the held request.
        tick();
        write = 1'b1; address = 32'd1032; writedata = 32'h11112222;
        tick(); tick(); tick(); #2;
        check("rstwr hi wen", wen, 0);
        check("rstwr hi addr", sram_addr, 18'd5);
        check("rstwr hi data", sram_data, 32'h1111);
        tb_drv_en = 1'b1; tb_drv_val = 16'hA5A5;
        rst = 1'b0;
        #1;
        check("rstwr wen", wen, 1);
        check("rstwr bus released", sram_data, 32'hA5A5);
        check("rstwr state", u_dut.state_q, 0);
        check("rstwr addr", sram_addr, 0);
        check("rstwr stall", nr, 1);
        tb_drv_en = 1'b0;
        tick(); #2;
        check("rstwr state held", u_dut.state_q, 0);
        tick();
        rst = 1'b1;
        #2;
        check("rstwr restart c0", nr, 1);
        for (int c = 1; c <= 4; c++) begin
            tick(); #2;
            check($sformatf("rstwr wen c%0d", c), wen, 0);
            check($sformatf("rstwr addr c%0d", c), sram_addr, (c <= 2) ? 18'd4 : 18'd5);
            check($sformatf("rstwr data c%0d", c), sram_data, (c <= 2) ? 32'h2222 : 32'h1111);
        end
        tick(); #2;
        check("rstwr done stall", nr, 0);
        tick();
        write = 1'b0;
        do_read("rd1032", 32'd1032, 18'd4, 32'h11112222);

        // Request dropped in LO still completes; then a back-to-back request.
        tick();
        read = 1'b1; address = 32'd1028;
        #2;
        check("drop c0 stall", nr, 1);
        tick();
        read = 1'b0;
        #2;
        check("drop c1 stall", nr, 0);
        check("drop c1 addr", sram_addr, 18'd2);
        tick(); tick(); #2;
        check("drop c3 addr", sram_addr, 18'd3);
        check("drop c3 state", u_dut.state_q, 2);
        tick(); #2;
        check("drop c4 rdata old", readdata, 32'h11112222);
        tick(); #2;
        check("drop c5 state", u_dut.state_q, 3);
        check("drop c5 rdata", readdata, 32'hDEADBEEF);
        tick();
        read = 1'b1; address = 32'd1024;
        #2;
        check("b2b c0 state", u_dut.state_q, 0);
        check("b2b c0 stall", nr, 1);
        tick(); tick(); tick(); tick(); tick(); #2;
        check("b2b c5 stall", nr, 0);
        check("b2b c5 rdata", readdata, 32'hCAFEF00D);
        tick();
        read = 1'b0;

        // WAIT_CYCLES=1: stall of three cycles.
        tick();
        read1 = 1'b1;
        #2;
        check("w1 c0 stall", nr1, 1);
        tick(); #2;
        check("w1 c1 stall", nr1, 1);
        check("w1 c1 addr", sram_addr1, 18'd2);
        tick(); #2;
        check("w1 c2 stall", nr1, 1);
        check("w1 c2 addr", sram_addr1, 18'd3);
        tick(); #2;
        check("w1 c3 stall", nr1, 0);
        tick();
        read1 = 1'b0;
        #2;
        check("w1 idle stall", nr1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
